// File: rtl/port_out_buffer.sv
// port_out_buffer
//
// Per-port egress FIFO that sits directly downstream of the switch write FSM.
// The FSM presents bytes with wr_en/port_addr/data_in. Bytes addressed to
// PORT_ID go into a circular buffer. The port consumer drains the buffer
// with rd_req and gets each byte back on a registered data_out/data_valid
// pair one cycle later. port_busy tells the FSM to stall while the buffer
// is full.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous, active-low reset
//   wr_en      write strobe from the switch FSM
//   port_addr  destination address that qualifies wr_en
//   data_in    write data
//   rd_req     consumer read request
//   data_out   registered read data; holds its last value between reads
//   data_valid one-cycle pulse: data_out carries a new byte this cycle
//   port_busy  buffer full; upstream must not write
//   count      current occupancy, 0..DEPTH
//   drop_err   sticky flag, set when an addressed write hits a full buffer
module port_out_buffer #(
  parameter int W_WIDTH = 8,
  parameter int DEPTH   = 4,   // power of two, >= 2
  parameter int PORT_ID = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [W_WIDTH-1:0]       port_addr,
  input  logic [W_WIDTH-1:0]       data_in,
  input  logic                     rd_req,
  output logic [W_WIDTH-1:0]       data_out,
  output logic                     data_valid,
  output logic                     port_busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0]      count_reg, count_next;
  logic [W_WIDTH-1:0] data_out_reg;
  logic               data_valid_reg;
  logic               drop_err_reg, drop_err_next;

  logic hit;
  logic full;
  logic empty;
  logic do_wr;
  logic do_rd;

  // full/empty are taken from the registered count, so a read and a write
  // in the same cycle are judged against the pre-edge occupancy: a full
  // buffer rejects the write even though the read frees a slot, and an
  // empty buffer ignores the read even though the write fills one.
  assign hit   = wr_en && (port_addr == W_WIDTH'(PORT_ID));
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign do_wr = hit && !full;
  assign do_rd = rd_req && !empty;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    drop_err_next = drop_err_reg;

    // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
    if (do_wr) begin
      wr_ptr_next = wr_ptr_reg + AW'(1);
    end
    if (do_rd) begin
      rd_ptr_next = rd_ptr_reg + AW'(1);
    end

    unique case ({do_wr, do_rd})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase

    // Only traffic addressed to this port can overflow it.
    if (hit && full) begin
      drop_err_next = 1'b1;
    end
  end

  // Storage has no reset: contents are meaningless until written, and
  // leaving it reset-free keeps it mappable onto block RAM.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      drop_err_reg   <= 1'b0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      count_reg      <= count_next;
      drop_err_reg   <= drop_err_next;
      data_valid_reg <= do_rd;
      // data_out only changes on an accepted read; otherwise it keeps
      // showing the last byte delivered.
      if (do_rd) begin
        data_out_reg <= mem[rd_ptr_reg];
      end
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign count      = count_reg;
  assign drop_err   = drop_err_reg;
  assign port_busy  = full;

endmodule

// File: tb/tb_port_out_buffer.sv
// Testbench for port_out_buffer (PORT_ID=2, DEPTH=4, W_WIDTH=8).
// A queue-based reference model predicts occupancy, read data, the
// data_valid pulse and the sticky drop flag.
module tb_port_out_buffer;

  localparam int W_WIDTH = 8;
  localparam int DEPTH   = 4;
  localparam int PORT_ID = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [W_WIDTH-1:0] port_addr;
  logic [W_WIDTH-1:0] data_in;
  logic               rd_req;
  logic [W_WIDTH-1:0] data_out;
  logic               data_valid;
  logic               port_busy;
  logic [2:0]         count;
  logic               drop_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic [7:0] q[$];
  bit         m_drop;
  bit         m_valid;
  logic [7:0] m_dout;

  port_out_buffer #(
    .W_WIDTH(W_WIDTH),
    .DEPTH  (DEPTH),
    .PORT_ID(PORT_ID)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .port_addr (port_addr),
    .data_in   (data_in),
    .rd_req    (rd_req),
    .data_out  (data_out),
    .data_valid(data_valid),
    .port_busy (port_busy),
    .count     (count),
    .drop_err  (drop_err)
  );

  always #5 clk = ~clk;

  // Applies one cycle of stimulus at the falling edge, advances the model
  // using the pre-edge occupancy, and returns 1 time unit after the rising
  // edge so the caller can sample the outputs.
  task automatic drive(input bit w, input logic [7:0] a, input logic [7:0] d, input bit r);
    bit hit, was_full, rd_ok;
    @(negedge clk);
    wr_en = w; port_addr = a; data_in = d; rd_req = r;
    was_full = (q.size() == DEPTH);
    hit      = w && (a == 8'(PORT_ID));
    rd_ok    = r && (q.size() != 0);
    m_valid  = rd_ok;
    if (rd_ok) m_dout = q.pop_front();
    if (hit && !was_full) q.push_back(d);
    if (hit && was_full) m_drop = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_drop  = 1'b0;
    m_valid = 1'b0;
    m_dout  = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; port_addr = '0; data_in = '0; rd_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (count !== 3'd0 || port_busy !== 1'b0 || data_valid !== 1'b0 || drop_err !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: count=%0d busy=%b valid=%b drop=%b dout=%h, required 0 0 0 0 00",
               count, port_busy, data_valid, drop_err, data_out);
    end
  endtask

  task automatic test_basic();
    drive(1, 8'd2, 8'hA1, 0);
    checks++;
    if (count !== 3'd1 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_write: count=%0d valid=%b, required 1 0", count, data_valid);
    end
    drive(0, 8'd0, 8'h00, 1);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hA1 || count !== 3'd0) begin
      failures++;
      $display("FAIL basic_read: valid=%b dout=%h count=%0d, required 1 a1 0", data_valid, data_out, count);
    end
    drive(0, 8'd0, 8'h00, 0);
    checks++;
    if (data_valid !== 1'b0 || data_out !== 8'hA1) begin
      failures++;
      $display("FAIL basic_pulse: valid=%b dout=%h, required 0 a1", data_valid, data_out);
    end
  endtask

  task automatic test_filter();
    drive(1, 8'd3, 8'h5A, 0);
    checks++;
    if (count !== 3'd0 || drop_err !== 1'b0) begin
      failures++;
      $display("FAIL filter_empty: count=%0d drop=%b, required 0 0", count, drop_err);
    end
    for (int i = 0; i < DEPTH; i++) drive(1, 8'd2, 8'(8'h60 + i), 0);
    drive(1, 8'd3, 8'h77, 0);
    checks++;
    if (count !== 3'd4 || drop_err !== 1'b0 || port_busy !== 1'b1) begin
      failures++;
      $display("FAIL filter_full: count=%0d drop=%b busy=%b, required 4 0 1", count, drop_err, port_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 8'd0, 8'h00, 1);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 8'(8'h60 + i)) begin
        failures++;
        $display("FAIL filter_drain: valid=%b dout=%h, required 1 %h", data_valid, data_out, 8'(8'h60 + i));
      end
    end
    drive(0, 8'd0, 8'h00, 1);
    checks++;
    if (data_valid !== 1'b0 || count !== 3'd0) begin
      failures++;
      $display("FAIL underflow: valid=%b count=%0d, required 0 0", data_valid, count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) drive(1, 8'd2, vals[i], 0);
    checks++;
    if (count !== 3'd4 || port_busy !== 1'b1 || drop_err !== 1'b0) begin
      failures++;
      $display("FAIL full: count=%0d busy=%b drop=%b, required 4 1 0", count, port_busy, drop_err);
    end
    drive(1, 8'd2, 8'h55, 0);
    checks++;
    if (count !== 3'd4 || drop_err !== 1'b1) begin
      failures++;
      $display("FAIL overflow: count=%0d drop=%b, required 4 1", count, drop_err);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'd0, 8'h00, 1);
      checks++;
      if (data_valid !== 1'b1 || data_out !== vals[i]) begin
        failures++;
        $display("FAIL overflow_read%0d: valid=%b dout=%h, required 1 %h", i, data_valid, data_out, vals[i]);
      end
    end
    checks++;
    if (count !== 3'd0 || port_busy !== 1'b0) begin
      failures++;
      $display("FAIL overflow_empty: count=%0d busy=%b, required 0 0", count, port_busy);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) drive(1, 8'd2, 8'(8'h90 + i), 0);
    for (int i = 0; i < 3; i++) drive(0, 8'd0, 8'h00, 1);
    for (int i = 0; i < 4; i++) drive(1, 8'd2, 8'(8'hB0 + i), 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 8'd0, 8'h00, 1);
      checks++;
      if (data_valid !== 1'b1 || data_out !== 8'(8'hB0 + i)) begin
        failures++;
        $display("FAIL wrap_read%0d: valid=%b dout=%h, required 1 %h", i, data_valid, data_out, 8'(8'hB0 + i));
      end
    end
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL wrap_empty: count=%0d, required 0", count);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) drive(1, 8'd2, 8'(8'hD0 + i), 0);
    drive(1, 8'd2, 8'hEE, 1);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hD0 || count !== 3'd3 || port_busy !== 1'b0) begin
      failures++;
      $display("FAIL simul_full: valid=%b dout=%h count=%0d busy=%b, required 1 d0 3 0",
               data_valid, data_out, count, port_busy);
    end
    for (int i = 1; i < 4; i++) begin
      drive(0, 8'd0, 8'h00, 1);
      checks++;
      if (data_out !== 8'(8'hD0 + i)) begin
        failures++;
        $display("FAIL simul_drain: dout=%h, required %h", data_out, 8'(8'hD0 + i));
      end
    end
    drive(1, 8'd2, 8'hC7, 1);
    checks++;
    if (count !== 3'd1 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL simul_empty: count=%0d valid=%b, required 1 0", count, data_valid);
    end
    drive(0, 8'd0, 8'h00, 1);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'hC7 || count !== 3'd0) begin
      failures++;
      $display("FAIL simul_c7: valid=%b dout=%h count=%0d, required 1 c7 0", data_valid, data_out, count);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive(1, 8'd2, 8'(8'h30 + i), 0);
    drive(0, 8'd0, 8'h00, 1);
    drive(0, 8'd0, 8'h00, 0);
    checks++;
    if (count !== 3'd3 || drop_err !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: count=%0d drop=%b, required 3 1", count, drop_err);
    end
    // Drop reset between clock edges and look before the next edge.
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || port_busy !== 1'b0 || drop_err !== 1'b0 || data_out !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: count=%0d busy=%b drop=%b dout=%h, required 0 0 0 00",
               count, port_busy, drop_err, data_out);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'd2, 8'h4D, 0);
    drive(0, 8'd0, 8'h00, 1);
    checks++;
    if (data_valid !== 1'b1 || data_out !== 8'h4D || count !== 3'd0) begin
      failures++;
      $display("FAIL post_reset: valid=%b dout=%h count=%0d, required 1 4d 0", data_valid, data_out, count);
    end
  endtask

  task automatic test_random();
    logic [7:0] a;
    bit w, r;
    for (int n = 0; n < 300; n++) begin
      w = ($urandom_range(0, 99) < 55);
      r = ($urandom_range(0, 99) < 45);
      case ($urandom_range(0, 3))
        0:       a = 8'd3;
        1:       a = 8'($urandom);
        default: a = 8'd2;
      endcase
      drive(w, a, 8'($urandom), r);
      checks++;
      if (count !== 3'(q.size()) || port_busy !== (q.size() == DEPTH) || data_valid !== m_valid ||
          drop_err !== m_drop || data_out !== m_dout) begin
        failures++;
        $display("FAIL random[%0d]: count=%0d busy=%b valid=%b drop=%b dout=%h, required %0d %b %b %b %h",
                 n, count, port_busy, data_valid, drop_err, data_out,
                 q.size(), (q.size() == DEPTH), m_valid, m_drop, m_dout);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_filter();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_out_buffer.md
Name: port_out_buffer

Overview:
- Per-port egress buffer that sits directly downstream of the switch write FSM.
- Captures bytes the FSM writes (wr_en, port_addr, data_in) when port_addr matches this port's ID.
- Stores them in a circular FIFO and presents them to the port consumer through a registered read handshake.
- Drives port_busy back to the FSM so that the FSM stalls while this buffer is full.

Parameters:
- W_WIDTH, 8: width of the data word and of the port address.
- DEPTH, 4: FIFO entries; must be a power of two and ≥ 2.
- PORT_ID, 0: address value this instance responds to (fits in W_WIDTH bits).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe from the switch FSM.
- port_addr  input  W_WIDTH  destination address qualifying wr_en.
- data_in  input  W_WIDTH  write data.
- rd_req  input  1  consumer read request.
- data_out  output  W_WIDTH  read data (registered).
- data_valid  output  1  one-cycle pulse: data_out valid this cycle.
- port_busy  output  1  buffer full; upstream must not write.
- count  output  $clog2(DEPTH)+1  current occupancy.
- drop_err  output  1  sticky overflow flag.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous and active-low.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, data_out=0, data_valid=0, drop_err=0, port_busy=0. Storage contents are don't-care. Reset mid-operation discards all stored data immediately, without waiting for a clock edge.
- hit = wr_en && (port_addr == PORT_ID).
- full = (count == DEPTH); empty = (count == 0); port_busy = full, combinational from registered count.
- Write: on a rising edge with hit && !full, mem[wr_ptr] <= data_in and wr_ptr increments modulo DEPTH. Pointers are $clog2(DEPTH) bits and wrap naturally.
- Read: on a rising edge with rd_req && !empty:
  - data_out <= mem[rd_ptr];
  - rd_ptr increments modulo DEPTH;
  - data_valid <= 1.
  Otherwise data_valid <= 0 and data_out holds its last value.
- Read latency: 1 cycle from the sampled rd_req to data_valid.
- Occupancy update:
  - write only: count+1;
  - read only: count−1;
  - both, or neither: count unchanged.
- Simultaneous cases:
  - Read and write while empty: the write is accepted; the read is ignored (no fall-through); data_valid=0.
  - Read and write while full: the read is accepted; the write is rejected, because full is evaluated on pre-edge state; count becomes DEPTH−1.
  - Read and write with 0 < count < DEPTH: both are performed; count is unchanged.
- Overflow: hit while full sets drop_err <= 1. The data is discarded and no pointer moves. drop_err is cleared only by reset.
- Underflow: rd_req while empty has no effect; data_valid=0, no error flag.
- Non-matching traffic: wr_en with port_addr ≠ PORT_ID is ignored entirely, including while full, and never sets drop_err.
- No internal state machine beyond the pointer/count datapath. count must never exceed DEPTH or wrap below 0.

Test Plan:
- Reset with PORT_ID=2, DEPTH=4 → count=0, port_busy=0, data_valid=0, drop_err=0. Write 0xA1 to addr 2, then rd_req one cycle later → data_valid pulses exactly 1 cycle after rd_req with data_out=0xA1; count returns to 0.
- Write 0x11, 0x22, 0x33, 0x44 to addr 2 → count=4 and port_busy=1 after the 4th edge. A 5th write of 0x55 → drop_err=1, count stays 4. Four reads → 0x11, 0x22, 0x33, 0x44 in order, and 0x55 never appears.
- Wrap-around: 3 writes, 3 reads, then 4 writes 0xB0..0xB3 and 4 reads → order preserved across the pointer wrap; count back to 0.
- Simultaneous: with the buffer full, rd_req + hit write of 0xEE → read accepted, count=3, 0xEE dropped. With the buffer empty, rd_req + write of 0xC7 → count=1, data_valid=0; the next read returns 0xC7.
- Address filter: wr_en with port_addr=3 while PORT_ID=2 → count unchanged, drop_err unchanged, including while full. rd_req with the buffer empty → no data_valid.
- Asynchronous reset: assert rst_n=0 mid-cycle with count=3 → count=0, port_busy=0, drop_err=0 immediately, without a clock edge. After release, the first write/read pair returns the new data only.
